// File: rtl/tick_gen_pkg.sv
// Shared types for the multi-channel tick generator: mode encoding and the
// per-channel configuration record passed from the decode logic to each channel.
package tick_gen_pkg;

  localparam logic [1:0] MODE_OFF        = 2'b00;
  localparam logic [1:0] MODE_INT_PULSE  = 2'b01;
  localparam logic [1:0] MODE_INT_SQUARE = 2'b10;
  localparam logic [1:0] MODE_NCO        = 2'b11;

  // Widest value a channel can hold; ACC_W of any instance must not exceed it.
  localparam int CFG_VALUE_W = 32;

  typedef enum logic [1:0] {
    OFF        = MODE_OFF,
    INT_PULSE  = MODE_INT_PULSE,
    INT_SQUARE = MODE_INT_SQUARE,
    NCO        = MODE_NCO
  } tick_mode_t;

  typedef struct packed {
    tick_mode_t             mode;
    logic [CFG_VALUE_W-1:0] value;
  } tick_cfg_t;

  function automatic logic is_int_mode(input logic [1:0] mode);
    return (mode == MODE_INT_PULSE) || (mode == MODE_INT_SQUARE);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: integer divider (pulse or square) or fractional NCO.
// A load or restart discards the current phase, including any pending tick.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int ACC_W = 24
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      load,
  input  tick_cfg_t cfg,
  input  logic      restart,
  output logic      tick,
  output logic      level
);

  tick_mode_t       mode_reg;
  logic [ACC_W-1:0] value_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             tick_reg;
  logic             level_reg;

  logic [DIV_W-1:0] div_n;
  logic             terminal;
  logic [ACC_W:0]   nco_sum;

  assign div_n    = value_reg[DIV_W-1:0];
  assign terminal = (cnt_reg == div_n - DIV_W'(1));
  // Carry out of the ACC_W-bit accumulator is the tick.
  assign nco_sum  = {1'b0, acc_reg} + {1'b0, value_reg};

  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_reg  <= OFF;
      value_reg <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      tick_reg  <= 1'b0;
      level_reg <= 1'b0;
    end else if (load) begin
      mode_reg  <= cfg.mode;
      value_reg <= cfg.value[ACC_W-1:0];
      cnt_reg   <= '0;
      acc_reg   <= '0;
      tick_reg  <= 1'b0;
      level_reg <= 1'b0;
    end else if (restart) begin
      cnt_reg   <= '0;
      acc_reg   <= '0;
      tick_reg  <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      case (mode_reg)
        INT_PULSE, INT_SQUARE: begin
          if (terminal) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
            if (mode_reg == INT_SQUARE) level_reg <= ~level_reg;
          end else begin
            cnt_reg  <= cnt_reg + DIV_W'(1);
            tick_reg <= 1'b0;
          end
        end
        NCO: begin
          {tick_reg, acc_reg} <= nco_sum;
        end
        default: begin
          cnt_reg   <= '0;
          acc_reg   <= '0;
          tick_reg  <= 1'b0;
          level_reg <= 1'b0;
        end
      endcase
    end
  end

  assign tick  = tick_reg;
  assign level = level_reg;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick / clock-enable generator: decodes config
// writes, rejects illegal ones with a one-cycle cfg_err, and fans out restart.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16,
  parameter int ACC_W    = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  input  logic [3:0]          cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [ACC_W-1:0]    cfg_value,
  input  logic                sync_restart,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] level,
  output logic                cfg_err
);

  logic      chan_bad;
  logic      reject;
  logic      cfg_err_reg;
  tick_cfg_t cfg;

  assign chan_bad = 32'(cfg_chan) >= 32'(CHANNELS);
  // Only the low DIV_W bits form N; higher bits are ignored in integer modes.
  assign reject   = chan_bad ||
                    (is_int_mode(cfg_mode) && (cfg_value[DIV_W-1:0] == '0));

  always_comb begin
    cfg       = '0;
    cfg.mode  = tick_mode_t'(cfg_mode);
    cfg.value = CFG_VALUE_W'(cfg_value);
  end

  always_ff @(posedge clock) begin
    if (!reset) cfg_err_reg <= 1'b0;
    else        cfg_err_reg <= cfg_valid && reject;
  end

  assign cfg_err = cfg_err_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic load;
      assign load = cfg_valid && !reject && (cfg_chan == 4'(gi));

      tick_channel #(
        .DIV_W (DIV_W),
        .ACC_W (ACC_W)
      ) u_chan (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .cfg     (cfg),
        .restart (sync_restart),
        .tick    (tick[gi]),
        .level   (level[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: a closed-form per-channel model pushes the
// expected outputs of each edge into a queue, popped and checked after the edge.
module tb_tick_gen_multi;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_chan = '0;
  logic [1:0]  cfg_mode = '0;
  logic [23:0] cfg_value = '0;
  logic        sync_restart = 1'b0;
  logic [3:0]  tick;
  logic [3:0]  level;
  logic        cfg_err;

  tick_gen_multi #(.CHANNELS(4), .DIV_W(16), .ACC_W(24)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_chan     (cfg_chan),
    .cfg_mode     (cfg_mode),
    .cfg_value    (cfg_value),
    .sync_restart (sync_restart),
    .tick         (tick),
    .level        (level),
    .cfg_err      (cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] tick;
    logic [3:0] level;
    logic       err;
  } exp_t;

  exp_t   exp_q[$];
  int     compared = 0;
  int     mismatched = 0;
  longint cyc = 0;
  int     mode_m[4];
  longint val_m[4];
  longint start_m[4];

  bit     track = 1'b0;
  int     nco_count = 0;
  longint last_tick = -1;
  longint min_gap = 1000000;

  // Expected channel outputs k edges after its last config/restart edge.
  function automatic void model_ch(input int ch, input longint t,
                                   output logic tk, output logic lv);
    longint k, n, inc;
    k   = t - start_m[ch];
    n   = val_m[ch] & 64'hFFFF;
    inc = val_m[ch] & 64'hFF_FFFF;
    tk  = 1'b0;
    lv  = 1'b0;
    case (mode_m[ch])
      1: tk = (k > 0) && (k % n == 0);
      2: begin
        tk = (k > 0) && (k % n == 0);
        lv = ((k / n) % 2) == 1;
      end
      3: tk = (k > 0) && (((k * inc) >> 24) != (((k - 1) * inc) >> 24));
      default: ;
    endcase
  endfunction

  task automatic cycle();
    exp_t e;
    exp_t got;
    logic tk, lv;
    logic bad;
    @(posedge clock);
    cyc++;
    e = '0;
    if (!reset) begin
      for (int c = 0; c < 4; c++) mode_m[c] = 0;
    end else begin
      bad = cfg_valid && ((int'(cfg_chan) >= 4) ||
            ((cfg_mode == 2'b01 || cfg_mode == 2'b10) && cfg_value[15:0] == 16'd0));
      e.err = bad;
      if (cfg_valid && !bad) begin
        mode_m[cfg_chan]  = int'(cfg_mode);
        val_m[cfg_chan]   = longint'(cfg_value);
        start_m[cfg_chan] = cyc;
      end
      if (sync_restart)
        for (int c = 0; c < 4; c++) start_m[c] = cyc;
    end
    for (int c = 0; c < 4; c++) begin
      model_ch(c, cyc, tk, lv);
      e.tick[c]  = tk;
      e.level[c] = lv;
    end
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    compared++;
    assert (tick === got.tick) else begin
      mismatched++;
      $error("FAIL tick @%0d: observed %b expected %b", cyc, tick, got.tick);
    end
    compared++;
    assert (level === got.level) else begin
      mismatched++;
      $error("FAIL level @%0d: observed %b expected %b", cyc, level, got.level);
    end
    compared++;
    assert (cfg_err === got.err) else begin
      mismatched++;
      $error("FAIL cfg_err @%0d: observed %b expected %b", cyc, cfg_err, got.err);
    end
    if (track && tick[2] === 1'b1) begin
      nco_count++;
      if (last_tick >= 0 && cyc - last_tick < min_gap) min_gap = cyc - last_tick;
      last_tick = cyc;
    end
    cfg_valid    = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input logic [3:0] ch, input logic [1:0] m, input logic [23:0] v,
                       input logic with_restart);
    cfg_valid    = 1'b1;
    cfg_chan     = ch;
    cfg_mode     = m;
    cfg_value    = v;
    sync_restart = with_restart;
    $display("write ch=%0d mode=%0d value=%0d restart=%0b at edge %0d", ch, m, v,
             with_restart, cyc + 1);
    cycle();
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      mode_m[c] = 0; val_m[c] = 0; start_m[c] = 0;
    end
    run(3);
    reset = 1'b1;
    run(2);
    write(4'd0, 2'b01, 24'd5, 1'b0);           // ticks at +5, +10, +15
    run(16);
    write(4'd0, 2'b01, 24'd1, 1'b0);           // N=1: tick every cycle
    run(5);
    write(4'd0, 2'b01, 24'd5, 1'b0);
    run(2);
    write(4'd1, 2'b10, 24'd3, 1'b0);           // square, period 6
    run(14);
    write(4'd5, 2'b01, 24'd7, 1'b0);           // bad channel
    run(3);
    write(4'd0, 2'b01, 24'd0, 1'b0);           // N=0 rejected
    run(8);
    write(4'd3, 2'b01, 24'hFF_0004, 1'b0);     // upper bits ignored, N=4
    run(9);
    sync_restart = 1'b1;
    $display("restart at edge %0d", cyc + 1);
    cycle();
    run(10);
    write(4'd3, 2'b01, 24'd6, 1'b1);           // write + restart together
    run(14);
    write(4'd2, 2'b11, 24'h80_0000, 1'b0);     // NCO half rate
    run(8);
    write(4'd1, 2'b10, 24'd3, 1'b0);           // rewrite mid-count
    run(7);
    reset = 1'b0;
    $display("reset pulse at edge %0d", cyc + 1);
    cycle();
    reset = 1'b1;
    run(6);
    write(4'd0, 2'b01, 24'd5, 1'b0);
    write(4'd2, 2'b11, 24'd96637, 1'b0);       // ~115200 baud at 20 MHz
    track = 1'b1;
    run(50000);
    track = 1'b0;
    $display("nco ticks=%0d min_gap=%0d", nco_count, min_gap);
    compared++;
    assert (nco_count == 288) else begin
      mismatched++;
      $error("FAIL nco_count: observed %0d expected 288", nco_count);
    end
    compared++;
    assert (min_gap >= 173) else begin
      mismatched++;
      $error("FAIL nco_min_gap: observed %0d expected >=173", min_gap);
    end
    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL queue_drain: observed %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
